// File: rtl/la_bitstream_bridge.sv
// la_bitstream_bridge: host-to-decoder bridge over LA pins; toggle-synced word FIFO streamed to the decoder, pixel/status readback
// Ports: wb_clk_i/wb_rst_i clock and sync reset; la_word_in/la_tog_in/la_oenb_tog host submission;
// la_clr_in host clear; m_data/m_valid/m_ready decoder stream; s_pix/s_pix_valid decoder pixels;
// la_ack_out/la_level_out/la_ovf_out/la_pix_out/la_cnt_out host readback.
module la_bitstream_bridge #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int PIX_W = 8,
  parameter int CNT_W = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DATA_W-1:0] la_word_in,
  input  logic              la_tog_in,
  input  logic              la_oenb_tog,
  input  logic              la_clr_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic [PIX_W-1:0]  s_pix,
  input  logic              s_pix_valid,
  output logic              la_ack_out,
  output logic [LVL_W-1:0]  la_level_out,
  output logic              la_ovf_out,
  output logic [PIX_W-1:0]  la_pix_out,
  output logic [CNT_W-1:0]  la_cnt_out
);
  localparam int PTR_W = LVL_W - 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);
  logic tog_s1_q, tog_s2_q, tog_prev_q, clr_s1_q, clr_s2_q;
  logic ack_q, ack_d, ovf_q, ovf_d;
  logic [1:0] arm_q, arm_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic evt, pop, push, drop;
  always_comb begin
    // tog_prev keeps tracking while disarmed, so a host that left la_tog_in high causes no submission
    evt = (tog_s2_q != tog_prev_q) && (arm_q == 2'd3) && !la_oenb_tog;
    pop = (lvl_q != '0) && m_ready;
    push = evt && ((lvl_q != FULL) || pop);
    drop = evt && (lvl_q == FULL) && !pop;
    arm_d = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    wr_d = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d = pop ? rd_q + PTR_W'(1) : rd_q;
    lvl_d = (push && !pop) ? lvl_q + LVL_W'(1) : (pop && !push) ? lvl_q - LVL_W'(1) : lvl_q;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = la_word_in;
    ack_d = ack_q ^ push;
    // a drop coinciding with clear still leaves overflow set
    ovf_d = drop | (ovf_q & !clr_s2_q);
    pix_d = s_pix_valid ? s_pix : pix_q;
    cnt_d = s_pix_valid ? (clr_s2_q ? CNT_W'(1) : cnt_q + CNT_W'(1)) : (clr_s2_q ? '0 : cnt_q);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      {tog_s1_q, tog_s2_q, tog_prev_q, clr_s1_q, clr_s2_q, ack_q, ovf_q} <= '0;
      arm_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      pix_q <= '0;
      cnt_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      tog_s1_q <= la_tog_in;
      tog_s2_q <= tog_s1_q;
      tog_prev_q <= tog_s2_q;
      clr_s1_q <= la_clr_in;
      clr_s2_q <= clr_s1_q;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
      arm_q <= arm_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      pix_q <= pix_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
  assign m_data = mem_q[rd_q];
  assign m_valid = lvl_q != '0;
  assign la_ack_out = ack_q;
  assign la_level_out = lvl_q;
  assign la_ovf_out = ovf_q;
  assign la_pix_out = pix_q;
  assign la_cnt_out = cnt_q;
endmodule

// File: tb/tb_la_bitstream_bridge.sv
// tb_la_bitstream_bridge: directed self-checking bench for la_bitstream_bridge
module tb_la_bitstream_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, tog, oenb, clr, m_ready, s_pix_valid, m_valid, ack, ovf;
  logic [15:0] word, m_data;
  logic [7:0] s_pix, pix;
  logic [3:0] cnt, level;
  int checks = 0, errors = 0;
  typedef struct {logic v; logic [7:0] p; logic [7:0] ep; logic [3:0] ec;} pix_vec_t;
  pix_vec_t tbl [19];
  la_bitstream_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .la_word_in(word), .la_tog_in(tog), .la_oenb_tog(oenb),
    .la_clr_in(clr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .s_pix(s_pix),
    .s_pix_valid(s_pix_valid), .la_ack_out(ack), .la_level_out(level), .la_ovf_out(ovf),
    .la_pix_out(pix), .la_cnt_out(cnt)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic submit(input logic [15:0] w);
    word = w;
    tog = ~tog;
    cyc(4);
  endtask
  initial begin
    int exp4 [8];
    exp4 = '{2, 3, 4, 5, 6, 7, 8, 10};
    tbl[0] = '{1'b1, 8'h01, 8'h01, 4'd1};   tbl[1] = '{1'b1, 8'h02, 8'h02, 4'd2};
    tbl[2] = '{1'b0, 8'hFF, 8'h02, 4'd2};   tbl[3] = '{1'b1, 8'h03, 8'h03, 4'd3};
    tbl[4] = '{1'b1, 8'h04, 8'h04, 4'd4};   tbl[5] = '{1'b1, 8'h05, 8'h05, 4'd5};
    tbl[6] = '{1'b1, 8'h06, 8'h06, 4'd6};   tbl[7] = '{1'b1, 8'h07, 8'h07, 4'd7};
    tbl[8] = '{1'b1, 8'h08, 8'h08, 4'd8};   tbl[9] = '{1'b0, 8'hEE, 8'h08, 4'd8};
    tbl[10] = '{1'b1, 8'h09, 8'h09, 4'd9};  tbl[11] = '{1'b1, 8'h0A, 8'h0A, 4'd10};
    tbl[12] = '{1'b1, 8'h0B, 8'h0B, 4'd11}; tbl[13] = '{1'b1, 8'h0C, 8'h0C, 4'd12};
    tbl[14] = '{1'b1, 8'h0D, 8'h0D, 4'd13}; tbl[15] = '{1'b1, 8'h0E, 8'h0E, 4'd14};
    tbl[16] = '{1'b1, 8'h0F, 8'h0F, 4'd15}; tbl[17] = '{1'b1, 8'h80, 8'h80, 4'd0};
    tbl[18] = '{1'b1, 8'h3C, 8'h3C, 4'd1};
    rst = 1; tog = 1; oenb = 0; clr = 0; m_ready = 0; s_pix_valid = 0; s_pix = 0; word = 0;
    cyc(3);
    chk("rst_level", level, 0); chk("rst_valid", m_valid, 0); chk("rst_ack", ack, 0);
    chk("rst_ovf", ovf, 0); chk("rst_pix", pix, 0); chk("rst_cnt", cnt, 0);
    rst = 0;
    cyc(6);
    chk("arm_level", level, 0); chk("arm_ack", ack, 0);
    word = 16'hA5A5; tog = 0;
    cyc(2);
    chk("lat_level_n1", level, 0);
    cyc(1);
    chk("wr_level", level, 1); chk("wr_valid", m_valid, 1);
    chk("wr_data", m_data, 16'hA5A5); chk("wr_ack", ack, 1);
    cyc(1); m_ready = 1; cyc(1); m_ready = 0;
    chk("pop_level", level, 0); chk("pop_valid", m_valid, 0);
    for (int i = 1; i <= 9; i++) submit(16'(i));
    chk("full_level", level, 8); chk("full_ovf", ovf, 1); chk("full_ack", ack, 1);
    chk("full_head", m_data, 1);
    clr = 1; cyc(3); clr = 0; cyc(3);
    chk("clr_ovf", ovf, 0); chk("clr_level", level, 8);
    word = 16'd10; tog = ~tog;
    cyc(2); m_ready = 1; cyc(1); m_ready = 0;
    chk("pp_level", level, 8); chk("pp_ovf", ovf, 0); chk("pp_ack", ack, 0);
    cyc(1);
    m_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("order_%0d", i), m_data, exp4[i]);
      cyc(1);
    end
    m_ready = 0;
    chk("drain_level", level, 0); chk("drain_valid", m_valid, 0);
    oenb = 1;
    for (int i = 0; i < 3; i++) submit(16'hBEEF);
    chk("oenb_level", level, 0); chk("oenb_ack", ack, 0);
    oenb = 0; cyc(3);
    chk("reen_level", level, 0);
    for (int i = 0; i < 8; i++) begin
      submit(16'h0100 + 16'(i));
      chk($sformatf("fill_ack_%0d", i), ack, (i + 1) % 2);
    end
    chk("fill_level", level, 8); chk("fill_ovf", ovf, 0);
    word = 16'hDEAD; tog = ~tog; clr = 1;
    cyc(1); clr = 0; cyc(2);
    chk("drop_clr_ovf", ovf, 1); chk("drop_level", level, 8); chk("drop_ack", ack, 0);
    cyc(3);
    chk("drop_ovf_sticky", ovf, 1);
    m_ready = 1; cyc(8); m_ready = 0;
    chk("drain2_level", level, 0);
    for (int i = 0; i < 19; i++) begin
      s_pix = tbl[i].p; s_pix_valid = tbl[i].v;
      cyc(1);
      chk($sformatf("pix_%0d", i), pix, tbl[i].ep);
      chk($sformatf("cnt_%0d", i), cnt, tbl[i].ec);
    end
    s_pix_valid = 0;
    clr = 1; cyc(3); clr = 0; cyc(3);
    chk("pclr_cnt", cnt, 0); chk("pclr_pix", pix, 8'h3C);
    s_pix_valid = 1; s_pix = 8'h11; cyc(1); s_pix = 8'h22; cyc(1); s_pix_valid = 0;
    chk("pre_cnt", cnt, 2);
    clr = 1; cyc(1); clr = 0; cyc(1);
    s_pix = 8'h55; s_pix_valid = 1; cyc(1); s_pix_valid = 0;
    chk("clr_pix_cnt", cnt, 1); chk("clr_pix_val", pix, 8'h55);
    cyc(2);
    chk("clr_pix_hold", cnt, 1);
    submit(16'h7777);
    chk("mid_level", level, 1); chk("mid_ack", ack, 1);
    rst = 1; cyc(1);
    chk("mrst_level", level, 0); chk("mrst_valid", m_valid, 0); chk("mrst_ack", ack, 0);
    chk("mrst_pix", pix, 0); chk("mrst_cnt", cnt, 0);
    rst = 0; cyc(6);
    chk("rearm_level", level, 0);
    submit(16'h1234);
    chk("rearm_push", level, 1); chk("rearm_data", m_data, 16'h1234); chk("rearm_ack", ack, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
